// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin arbiter onto a single register-file write port.
// Optional per-requester grant/conflict statistics under RF_ARB_STATS_EN.
module rf_write_arbiter #(
    parameter int unsigned N = 32,
    parameter int unsigned S = 32,
    localparam int unsigned M = $clog2(S)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a_valid,
    input  logic [M-1:0] a_addr,
    input  logic [N-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [M-1:0] b_addr,
    input  logic [N-1:0] b_data,
    output logic         b_ready,
    output logic         rf_we,
    output logic [M-1:0] rf_addr,
    output logic [N-1:0] rf_data
`ifdef RF_ARB_STATS_EN
    ,
    output logic [15:0]  a_grants,
    output logic [15:0]  b_grants,
    output logic [15:0]  conflicts
`endif
);

    localparam logic [0:0] PRI_A = 1'b0;
    localparam logic [0:0] PRI_B = 1'b1;

    logic [0:0]   pri_q;
    logic [0:0]   pri_d;
    logic         both_v;
    logic         grant_a;
    logic         grant_b;
    logic         grant_any;
    logic [M-1:0] win_addr;
    logic [N-1:0] win_data;

    // Priority pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri_q <= PRI_A;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Grant decision; the pointer only moves when both requesters compete
    always_comb begin
        pri_d   = pri_q;
        grant_a = 1'b0;
        grant_b = 1'b0;
        both_v  = a_valid && b_valid;
        if (rst_n) begin
            case (pri_q)
                PRI_A: begin
                    grant_a = a_valid;
                    grant_b = b_valid && !a_valid;
                    if (both_v) pri_d = PRI_B;
                end
                default: begin
                    grant_b = b_valid;
                    grant_a = a_valid && !b_valid;
                    if (both_v) pri_d = PRI_A;
                end
            endcase
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign grant_any = grant_a || grant_b;
    assign win_addr  = grant_b ? b_addr : a_addr;
    assign win_data  = grant_b ? b_data : a_data;

    // Registered write port; address 0 is accepted but never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= grant_any && (win_addr != '0);
            if (grant_any) begin
                rf_addr <= win_addr;
                rf_data <= win_data;
            end
        end
    end

`ifdef RF_ARB_STATS_EN
    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_grants  <= 16'd0;
            b_grants  <= 16'd0;
            conflicts <= 16'd0;
        end else begin
            if (grant_a && (a_grants != 16'hFFFF)) a_grants <= a_grants + 16'd1;
            if (grant_b && (b_grants != 16'hFFFF)) b_grants <= b_grants + 16'd1;
            if (both_v && (conflicts != 16'hFFFF)) conflicts <= conflicts + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a randomized
// run against a transaction-level model. Statistics checked when RF_ARB_STATS_EN is set.
module tb_rf_write_arbiter;

    localparam int unsigned N = 32;
    localparam int unsigned S = 32;
    localparam int unsigned M = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_valid, b_valid;
    logic [M-1:0] a_addr, b_addr;
    logic [N-1:0] a_data, b_data;
    logic         a_ready, b_ready;
    logic         rf_we;
    logic [M-1:0] rf_addr;
    logic [N-1:0] rf_data;
`ifdef RF_ARB_STATS_EN
    logic [15:0]  a_grants, b_grants, conflicts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rf_write_arbiter #(.N(N), .S(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
`ifdef RF_ARB_STATS_EN
        , .a_grants(a_grants), .b_grants(b_grants), .conflicts(conflicts)
`endif
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT write port
    logic [N-1:0] tb_rf [S];
    int commits = 0;
    always @(posedge clk) begin
        if (rf_we) begin
            tb_rf[rf_addr] <= rf_data;
            commits <= commits + 1;
        end
    end

    // Transaction-level model: who has priority, last write, grant tallies
    logic         m_prio;
    logic         m_we;
    logic [M-1:0] m_addr;
    logic [N-1:0] m_data;
    int           m_ag, m_bg, m_cf;

    task automatic model_reset();
        m_prio = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
        m_ag = 0; m_bg = 0; m_cf = 0;
    endtask

    task automatic drive(input logic av, input logic [M-1:0] aa, input logic [N-1:0] ad,
                         input logic bv, input logic [M-1:0] ba, input logic [N-1:0] bd);
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h1234;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h5678;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", rf_we); end
        n_checks++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", rf_addr); end
        n_checks++; if (rf_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rf_data); end
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b expected 0", b_ready); end
`ifdef RF_ARB_STATS_EN
        n_checks++; if ({a_grants, b_grants, conflicts} !== 48'd0) begin
            n_fail++; $display("FAIL reset_stats: got %h/%h/%h expected 0/0/0", a_grants, b_grants, conflicts); end
`endif
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        drive(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0);
        n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready: got %b expected 1", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL single_b_ready: got %b expected 0", b_ready); end
        @(posedge clk); #1;
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b expected 1", rf_we); end
        n_checks++; if (rf_addr !== 5'd5) begin n_fail++; $display("FAIL single_addr: got %h expected 5", rf_addr); end
        n_checks++; if (rf_data !== 32'hAA) begin n_fail++; $display("FAIL single_data: got %h expected aa", rf_data); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL idle_ready: got %b expected 00", {a_ready, b_ready}); end
        @(posedge clk); #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %b expected 0", rf_we); end
        n_checks++; if ({rf_addr, rf_data} !== {5'd5, 32'hAA}) begin
            n_fail++; $display("FAIL idle_hold: got %h/%h expected 5/aa", rf_addr, rf_data); end
    endtask

    task automatic test_round_robin();
        logic exp_a;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2) == 0;
            drive(1'b1, 5'd3, 32'hA3, 1'b1, 5'd7, 32'hB7);
            n_checks++; if ({a_ready, b_ready} !== {exp_a, !exp_a}) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", i, {a_ready, b_ready}, {exp_a, !exp_a}); end
            @(posedge clk); #1;
            n_checks++; if ({rf_we, rf_addr} !== {1'b1, exp_a ? 5'd3 : 5'd7}) begin
                n_fail++; $display("FAIL rr_write%0d: got we=%b addr=%0d expected we=1 addr=%0d", i, rf_we, rf_addr, exp_a ? 3 : 7); end
        end
    endtask

    task automatic test_addr0();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL addr0_ready: got %b expected 1", b_ready); end
        @(posedge clk); #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL addr0_we: got %b expected 0", rf_we); end
        n_checks++; if ({rf_addr, rf_data} !== {5'd0, 32'hFFFF_FFFF}) begin
            n_fail++; $display("FAIL addr0_update: got %h/%h expected 0/ffffffff", rf_addr, rf_data); end
    endtask

    task automatic test_collision();
        drive(1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22);
        n_checks++; if ({a_ready, b_ready} !== 2'b10) begin n_fail++; $display("FAIL coll_grant1: got %b expected 10", {a_ready, b_ready}); end
        @(posedge clk); #1;
        n_checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd9, 32'h11}) begin
            n_fail++; $display("FAIL coll_write1: got %b/%h/%h expected 1/9/11", rf_we, rf_addr, rf_data); end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h22);
        n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL coll_grant2: got %b expected 1", b_ready); end
        @(posedge clk); #1;
        n_checks++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd9, 32'h22}) begin
            n_fail++; $display("FAIL coll_write2: got %b/%h/%h expected 1/9/22", rf_we, rf_addr, rf_data); end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        n_checks++; if (tb_rf[9] !== 32'h22) begin n_fail++; $display("FAIL coll_final: got %h expected 22", tb_rf[9]); end
    endtask

    task automatic test_reset_mid();
        int c0;
        do_reset();
        drive(1'b1, 5'd12, 32'h55, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL mid_we_before: got %b expected 1", rf_we); end
        c0 = commits;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_we_async: got %b expected 0", rf_we); end
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b expected 0", a_ready); end
        @(posedge clk); #1;
        n_checks++; if (commits !== c0) begin n_fail++; $display("FAIL mid_commit: got %0d commits expected %0d", commits, c0); end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h4);
        n_checks++; if ({a_ready, b_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_prio: got %b expected 10", {a_ready, b_ready}); end
        @(posedge clk);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
    endtask

    task automatic test_random();
        logic         pa, pb, ga, gb;
        logic [M-1:0] qa, qb;
        logic [N-1:0] da, db;
        do_reset();
        pa = 1'b0; pb = 1'b0; qa = '0; qb = '0; da = '0; db = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && $urandom_range(0, 3) != 0) begin pa = 1'b1; qa = M'($urandom_range(0, 7)); da = $urandom; end
            if (!pb && $urandom_range(0, 3) != 0) begin pb = 1'b1; qb = M'($urandom_range(0, 7)); db = $urandom; end
            drive(pa, qa, da, pb, qb, db);
            ga = pa && (!pb || !m_prio);
            gb = pb && (!pa || m_prio);
            n_checks++; if ({a_ready, b_ready} !== {ga, gb}) begin
                n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", i, {a_ready, b_ready}, {ga, gb}); end
            @(posedge clk);
            if (pa && pb) begin m_cf++; m_prio = !m_prio; end
            if (ga) begin m_ag++; m_addr = qa; m_data = da; end
            if (gb) begin m_bg++; m_addr = qb; m_data = db; end
            m_we = (ga || gb) && (m_addr != 0);
            #1;
            n_checks++; if ({rf_we, rf_addr, rf_data} !== {m_we, m_addr, m_data}) begin
                n_fail++; $display("FAIL rand_write@%0d: got %b/%h/%h expected %b/%h/%h", i, rf_we, rf_addr, rf_data, m_we, m_addr, m_data); end
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
`ifdef RF_ARB_STATS_EN
        n_checks++; if ({a_grants, b_grants, conflicts} !== {16'(m_ag), 16'(m_bg), 16'(m_cf)}) begin
            n_fail++; $display("FAIL rand_stats: got %0d/%0d/%0d expected %0d/%0d/%0d", a_grants, b_grants, conflicts, m_ag, m_bg, m_cf); end
`endif
    endtask

`ifdef RF_ARB_STATS_EN
    task automatic test_stats_saturate();
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            drive(1'b1, 5'd1, 32'(i), 1'b0, 5'd0, 32'd0);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++; if ({a_grants, b_grants, conflicts} !== {16'hFFFF, 16'd0, 16'd0}) begin
            n_fail++; $display("FAIL stats_sat: got %h/%h/%h expected ffff/0/0", a_grants, b_grants, conflicts); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_addr0();
        test_collision();
        test_reset_mid();
        test_random();
`ifdef RF_ARB_STATS_EN
        test_stats_saturate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter N, default 32, data width of each register-file write.
REQ-002 Parameter S, default 32, number of architectural registers; M = $clog2(S) is the address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-006 a_addr  input  M  requester A destination register.
REQ-007 a_data  input  N  requester A write data.
REQ-008 a_ready  output  1  requester A write accepted this cycle.
REQ-009 b_valid / b_addr / b_data / b_ready  same widths and meanings for requester B (load / multi-cycle unit).
REQ-010 rf_we  output  1  register-file write enable, registered.
REQ-011 rf_addr  output  M  register-file write address, registered.
REQ-012 rf_data  output  N  register-file write data, registered.

Function
REQ-013 The block SHALL merge two write requesters onto the single register-file write port, at most one grant per cycle.
REQ-014 A transfer occurs on a cycle where x_valid and x_ready are both high; x_ready SHALL be combinational from the valid inputs and the priority pointer only, never from x_ready of the other requester.
REQ-015 Only one requester valid: it SHALL be granted that cycle; the priority pointer is unchanged.
REQ-016 Both valid: the requester named by the priority pointer SHALL be granted; the pointer then SHALL point to the other requester (round-robin, no starvation beyond one cycle).
REQ-017 Neither valid: a_ready = b_ready = 0; rf_we SHALL be 0 on the next cycle.
REQ-018 Latency: a write accepted in cycle T SHALL appear on rf_we/rf_addr/rf_data in cycle T+1 and be committed by the register file on the edge ending T+1.
REQ-019 Writes to address 0 SHALL be accepted (ready high) but rf_we SHALL stay 0 in T+1; rf_addr/rf_data are still updated.
REQ-020 Requesters SHALL hold valid, addr, and data stable until accepted; the block does not buffer unaccepted requests.
REQ-021 Same-address collision (both valid, equal nonzero addr): the granted write commits first, the other in the following cycle, so the loser's data is the final register value.
REQ-022 rf_addr/rf_data SHALL hold their last values when rf_we is 0.

Reset
REQ-023 While rst_n = 0: rf_we = 0, rf_addr = 0, rf_data = 0, a_ready = b_ready = 0, priority pointer = A, statistics counters = 0.
REQ-024 Reset asserted mid-operation SHALL drop any write registered for the next cycle (rf_we forced 0 immediately, asynchronously).
REQ-025 First edge after rst_n deasserts SHALL arbitrate normally, A having priority.

Configuration
REQ-026 Macro RF_ARB_STATS_EN defined: extra outputs a_grants and b_grants, each 16-bit, SHALL count grants per requester, including address-0 grants, saturating at 16'hFFFF; plus output conflicts, 16-bit saturating, counting both-valid cycles.
REQ-027 RF_ARB_STATS_EN undefined: those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-028 Reset, then a_valid = 1, a_addr = 5, a_data = 0x0000_00AA for one cycle -> a_ready = 1 that cycle; next cycle rf_we = 1, rf_addr = 5, rf_data = 0xAA.
REQ-029 Both valid for 4 cycles with distinct addrs 3 (A) and 7 (B) and each requester holding until accepted -> grants A, B, A, B; rf_addr sequence 3, 7, 3, 7, each one cycle after its grant.
REQ-030 b_valid = 1, b_addr = 0, b_data = 0xFFFF_FFFF -> b_ready = 1; next cycle rf_we = 0.
REQ-031 Both valid, addr 9, a_data = 0x11, b_data = 0x22, pointer = A -> rf_we pulses twice at addr 9, data 0x11 then 0x22; register 9 ends at 0x22.
REQ-032 Grant A in cycle T, rst_n pulled low in T+1 before the edge -> rf_we goes 0 immediately, no write commits, and after release A has priority.
REQ-033 With RF_ARB_STATS_EN: 70000 consecutive A-only grants -> a_grants = 0xFFFF, b_grants = 0, conflicts = 0.
